// File: rtl/free_list_if.sv
// Rename-side interface of the physical-register free list: dispatch pop request,
// ROB retire push lanes, misprediction recovery and the tags and count it presents.
interface free_list_if #(
   parameter int PREG_NUMBER     = 64,
   parameter int ARCH_REG_NUMBER = 32
);
   localparam int FL_SIZE = PREG_NUMBER - ARCH_REG_NUMBER;
   localparam int TAG_W   = $clog2(PREG_NUMBER);
   localparam int CNT_W   = $clog2(FL_SIZE) + 1;

   logic                       dispatch_en_i;
   logic                       dispatch_size_i;
   logic [1:0]                 retire_en_i;
   logic [1:0][TAG_W-1:0]      T_old_i;
   logic                       branch_mispredicted_i;
   logic [1:0][TAG_W-1:0]      freeReg_o;
   logic [CNT_W-1:0]           free_count_o;
   logic                       fl_empty_o;
   logic                       fl_one_left_o;

   modport master (
      output dispatch_en_i, dispatch_size_i, retire_en_i, T_old_i, branch_mispredicted_i,
      input  freeReg_o, free_count_o, fl_empty_o, fl_one_left_o
   );

   modport slave (
      input  dispatch_en_i, dispatch_size_i, retire_en_i, T_old_i, branch_mispredicted_i,
      output freeReg_o, free_count_o, fl_empty_o, fl_one_left_o
   );
endinterface

// File: rtl/free_list.sv
// 2-wide circular free list of physical register tags with speculative/architectural heads.
// Optional FL_DEBUG_EN macro exposes the registered pointers and enables protocol assertions.
module free_list #(
   parameter int PREG_NUMBER     = 64,
   parameter int ARCH_REG_NUMBER = 32
) (
   input  logic clk,
   input  logic reset,
`ifdef FL_DEBUG_EN
   output logic [$clog2(PREG_NUMBER-ARCH_REG_NUMBER)-1:0] spec_head_debug,
   output logic [$clog2(PREG_NUMBER-ARCH_REG_NUMBER)-1:0] arch_head_debug,
   output logic [$clog2(PREG_NUMBER-ARCH_REG_NUMBER)-1:0] tail_debug,
`endif
   free_list_if.slave fl
);
   localparam int FL_SIZE = PREG_NUMBER - ARCH_REG_NUMBER;
   localparam int TAG_W   = $clog2(PREG_NUMBER);
   localparam int PTR_W   = $clog2(FL_SIZE);
   localparam int CNT_W   = PTR_W + 1;

   logic [TAG_W-1:0] list_q [FL_SIZE];
   logic [PTR_W-1:0] spec_head_q, arch_head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   logic [PTR_W-1:0] spec_head_d, arch_head_d, tail_d, tail_lane1, spec_head_p1;
   logic [CNT_W-1:0] count_d, npop, npush, pop_amt;
   logic             pop_ok;

   always_comb begin
      npop        = fl.dispatch_size_i ? CNT_W'(2) : CNT_W'(1);
      npush       = CNT_W'(fl.retire_en_i[0]) + CNT_W'(fl.retire_en_i[1]);
      // all-or-nothing pop against the count seen at cycle start
      pop_ok      = fl.dispatch_en_i && !fl.branch_mispredicted_i && (npop <= count_q);
      pop_amt     = pop_ok ? npop : '0;
      tail_lane1  = tail_q + PTR_W'(fl.retire_en_i[0]);
      tail_d      = tail_q + npush[PTR_W-1:0];
      arch_head_d = arch_head_q + npush[PTR_W-1:0];
      spec_head_d = spec_head_q + pop_amt[PTR_W-1:0];
      count_d     = count_q - pop_amt + npush;
      if (fl.branch_mispredicted_i) begin
         spec_head_d = arch_head_d;
         count_d     = CNT_W'(FL_SIZE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spec_head_q <= '0;
         arch_head_q <= '0;
         tail_q      <= '0;
         count_q     <= CNT_W'(FL_SIZE);
      end else begin
         spec_head_q <= spec_head_d;
         arch_head_q <= arch_head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
      end
   end

   // lane 1 packs behind lane 0, or into the tail slot itself when lane 0 is idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FL_SIZE; i++) begin
            list_q[i] <= TAG_W'(ARCH_REG_NUMBER + i);
         end
      end else begin
         if (fl.retire_en_i[0]) list_q[tail_q]     <= fl.T_old_i[0];
         if (fl.retire_en_i[1]) list_q[tail_lane1] <= fl.T_old_i[1];
      end
   end

   assign spec_head_p1     = spec_head_q + PTR_W'(1);
   assign fl.freeReg_o[0]  = list_q[spec_head_q];
   assign fl.freeReg_o[1]  = list_q[spec_head_p1];
   assign fl.free_count_o  = count_q;
   assign fl.fl_empty_o    = (count_q == '0);
   assign fl.fl_one_left_o = (count_q == CNT_W'(1));

`ifdef FL_DEBUG_EN
   assign spec_head_debug = spec_head_q;
   assign arch_head_debug = arch_head_q;
   assign tail_debug      = tail_q;

   a_no_double_free : assert property (@(posedge clk) disable iff (!reset)
      !((npush != '0) && (count_q == CNT_W'(FL_SIZE))))
      else $error("free_list: retire push while list already full");

   a_pop_within_count : assert property (@(posedge clk) disable iff (!reset)
      pop_ok |-> (npop <= count_q))
      else $error("free_list: accepted pop exceeds free count");
`endif
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic
// checked against a queue-based model of the speculative and architectural free lists.
module tb_free_list;
   localparam int PREG = 64;
   localparam int ARCH = 32;
   localparam int FLS  = PREG - ARCH;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   free_list_if #(.PREG_NUMBER(PREG), .ARCH_REG_NUMBER(ARCH)) fl ();

`ifdef FL_DEBUG_EN
   logic [4:0] spec_dbg, arch_dbg, tail_dbg;
`endif

   free_list #(.PREG_NUMBER(PREG), .ARCH_REG_NUMBER(ARCH)) dut (
      .clk(clk),
      .reset(reset),
`ifdef FL_DEBUG_EN
      .spec_head_debug(spec_dbg),
      .arch_head_debug(arch_dbg),
      .tail_debug(tail_dbg),
`endif
      .fl(fl)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // spec_q: tags free from the speculative view, oldest first.
   // arch_q: tags free from the retired view (always FLS entries).
   int spec_q[$];
   int arch_q[$];

   task automatic model_reset();
      spec_q.delete();
      arch_q.delete();
      for (int i = 0; i < FLS; i++) begin
         spec_q.push_back(ARCH + i);
         arch_q.push_back(ARCH + i);
      end
   endtask

   task automatic idle_inputs();
      fl.dispatch_en_i         = 1'b0;
      fl.dispatch_size_i       = 1'b0;
      fl.retire_en_i           = 2'b00;
      fl.T_old_i[0]            = '0;
      fl.T_old_i[1]            = '0;
      fl.branch_mispredicted_i = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus; the model consumes cycle-start state, pops before pushes.
   task automatic cycle(input bit en, input bit sz, input bit [1:0] ret,
                        input logic [5:0] t0, input logic [5:0] t1, input bit mis);
      int np;
      fl.dispatch_en_i         = en;
      fl.dispatch_size_i       = sz;
      fl.retire_en_i           = ret;
      fl.T_old_i[0]            = t0;
      fl.T_old_i[1]            = t1;
      fl.branch_mispredicted_i = mis;
      np = sz ? 2 : 1;
      if (en && !mis && np <= spec_q.size())
         repeat (np) void'(spec_q.pop_front());
      if (ret[0]) begin
         spec_q.push_back(int'(t0));
         void'(arch_q.pop_front());
         arch_q.push_back(int'(t0));
      end
      if (ret[1]) begin
         spec_q.push_back(int'(t1));
         void'(arch_q.pop_front());
         arch_q.push_back(int'(t1));
      end
      if (mis) spec_q = arch_q;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (fl.free_count_o !== 6'd32) begin
         n_fail++; $display("FAIL reset_count got %0d exp 32", fl.free_count_o);
      end
      n_tests++;
      if (fl.freeReg_o[0] !== 6'd32 || fl.freeReg_o[1] !== 6'd33) begin
         n_fail++; $display("FAIL reset_tags got {%0d,%0d} exp {32,33}", fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      n_tests++;
      if (fl.fl_empty_o !== 1'b0 || fl.fl_one_left_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got empty=%b one=%b exp 0,0", fl.fl_empty_o, fl.fl_one_left_o);
      end
`ifdef FL_DEBUG_EN
      n_tests++;
      if (spec_dbg !== 5'd0 || arch_dbg !== 5'd0 || tail_dbg !== 5'd0) begin
         n_fail++; $display("FAIL reset_ptrs got %0d/%0d/%0d exp 0/0/0", spec_dbg, arch_dbg, tail_dbg);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      cycle(0, 0, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd32 || fl.freeReg_o[0] !== 6'd32) begin
         n_fail++; $display("FAIL idle_after_reset got cnt=%0d tag=%0d exp 32,32", fl.free_count_o, fl.freeReg_o[0]);
      end
   endtask

   task automatic test_pop_sizes();
      apply_reset();
      cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.freeReg_o[0] !== 6'd34 || fl.freeReg_o[1] !== 6'd35 || fl.free_count_o !== 6'd30) begin
         n_fail++; $display("FAIL pop2 got {%0d,%0d} cnt=%0d exp {34,35} 30",
                            fl.freeReg_o[0], fl.freeReg_o[1], fl.free_count_o);
      end
      cycle(1, 0, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.freeReg_o[0] !== 6'd35 || fl.freeReg_o[1] !== 6'd36 || fl.free_count_o !== 6'd29) begin
         n_fail++; $display("FAIL pop1 got {%0d,%0d} cnt=%0d exp {35,36} 29",
                            fl.freeReg_o[0], fl.freeReg_o[1], fl.free_count_o);
      end
   endtask

   task automatic test_drain_empty();
      apply_reset();
      repeat (16) cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd0 || fl.fl_empty_o !== 1'b1 || fl.fl_one_left_o !== 1'b0) begin
         n_fail++; $display("FAIL drain got cnt=%0d empty=%b one=%b exp 0,1,0",
                            fl.free_count_o, fl.fl_empty_o, fl.fl_one_left_o);
      end
      cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd0) begin
         n_fail++; $display("FAIL pop_when_empty got cnt=%0d exp 0", fl.free_count_o);
      end
      cycle(0, 0, 2'b11, 6'd1, 6'd2, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd2 || fl.freeReg_o[0] !== 6'd1 || fl.freeReg_o[1] !== 6'd2) begin
         n_fail++; $display("FAIL refill got cnt=%0d {%0d,%0d} exp 2 {1,2}",
                            fl.free_count_o, fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      cycle(1, 0, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd1 || fl.fl_one_left_o !== 1'b1 || fl.freeReg_o[0] !== 6'd2) begin
         n_fail++; $display("FAIL one_left got cnt=%0d one=%b tag=%0d exp 1,1,2",
                            fl.free_count_o, fl.fl_one_left_o, fl.freeReg_o[0]);
      end
      cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd1 || fl.freeReg_o[0] !== 6'd2) begin
         n_fail++; $display("FAIL no_partial_pop got cnt=%0d tag=%0d exp 1,2", fl.free_count_o, fl.freeReg_o[0]);
      end
      cycle(1, 0, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd0 || fl.fl_empty_o !== 1'b1) begin
         n_fail++; $display("FAIL last_pop got cnt=%0d empty=%b exp 0,1", fl.free_count_o, fl.fl_empty_o);
      end
   endtask

   task automatic test_mispredict();
      apply_reset();
      repeat (3) cycle(1, 1, 2'b00, 0, 0, 0);
      cycle(0, 0, 2'b01, 6'd3, 6'd0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd27 || fl.freeReg_o[0] !== 6'd38) begin
         n_fail++; $display("FAIL retire_one got cnt=%0d tag=%0d exp 27,38", fl.free_count_o, fl.freeReg_o[0]);
      end
`ifdef FL_DEBUG_EN
      n_tests++;
      if (arch_dbg !== 5'd1 || tail_dbg !== 5'd1 || spec_dbg !== 5'd6) begin
         n_fail++; $display("FAIL retire_ptrs got s=%0d a=%0d t=%0d exp 6,1,1", spec_dbg, arch_dbg, tail_dbg);
      end
`endif
      cycle(1, 1, 2'b00, 0, 0, 1);
      n_tests++;
      if (fl.free_count_o !== 6'd32 || fl.freeReg_o[0] !== 6'd33 || fl.freeReg_o[1] !== 6'd34) begin
         n_fail++; $display("FAIL mispredict got cnt=%0d {%0d,%0d} exp 32 {33,34}",
                            fl.free_count_o, fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      cycle(1, 1, 2'b00, 0, 0, 0);
      cycle(1, 1, 2'b10, 6'd0, 6'd9, 1);
      n_tests++;
      if (fl.free_count_o !== 6'd32 || fl.freeReg_o[0] !== 6'd34 || fl.freeReg_o[1] !== 6'd35) begin
         n_fail++; $display("FAIL mispredict_retire got cnt=%0d {%0d,%0d} exp 32 {34,35}",
                            fl.free_count_o, fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      // the lane-1-only retire must have landed right after tag 3 in the ring
      repeat (14) cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd4 || fl.freeReg_o[0] !== 6'd62 || fl.freeReg_o[1] !== 6'd63) begin
         n_fail++; $display("FAIL ring_order_a got cnt=%0d {%0d,%0d} exp 4 {62,63}",
                            fl.free_count_o, fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.freeReg_o[0] !== 6'd3 || fl.freeReg_o[1] !== 6'd9) begin
         n_fail++; $display("FAIL ring_order_b got {%0d,%0d} exp {3,9}", fl.freeReg_o[0], fl.freeReg_o[1]);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      cycle(1, 1, 2'b00, 0, 0, 0);
      n_tests++;
      if (fl.freeReg_o[0] !== 6'd34 || fl.freeReg_o[1] !== 6'd35) begin
         n_fail++; $display("FAIL b2b_presented got {%0d,%0d} exp {34,35}", fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      cycle(1, 1, 2'b11, 6'd5, 6'd6, 0);
      n_tests++;
      if (fl.free_count_o !== 6'd30 || fl.freeReg_o[0] !== 6'd36 || fl.freeReg_o[1] !== 6'd37) begin
         n_fail++; $display("FAIL b2b_net_zero got cnt=%0d {%0d,%0d} exp 30 {36,37}",
                            fl.free_count_o, fl.freeReg_o[0], fl.freeReg_o[1]);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (3) cycle(1, 1, 2'b00, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if (fl.free_count_o !== 6'd32 || fl.freeReg_o[0] !== 6'd32 || fl.freeReg_o[1] !== 6'd33) begin
         n_fail++; $display("FAIL async_reset got cnt=%0d {%0d,%0d} exp 32 {32,33}",
                            fl.free_count_o, fl.freeReg_o[0], fl.freeReg_o[1]);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap();
      int inflight;
      bit [1:0] ret;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         inflight = FLS - spec_q.size();
         ret = (i % 5 == 4) ? 2'b10 : 2'b11;
         if (inflight == 0) ret = 2'b00;
         else if (inflight == 1 && ret == 2'b11) ret = 2'b01;
         cycle(1, 1, ret, 6'((i * 7 + 1) % 64), 6'((i * 7 + 4) % 64), 0);
         n_tests++;
         if (fl.free_count_o !== 6'(spec_q.size())) begin
            n_fail++; $display("FAIL wrap_count cyc %0d got %0d exp %0d", i, fl.free_count_o, spec_q.size());
         end
         if (spec_q.size() >= 2) begin
            n_tests++;
            if (fl.freeReg_o[0] !== 6'(spec_q[0]) || fl.freeReg_o[1] !== 6'(spec_q[1])) begin
               n_fail++; $display("FAIL wrap_tags cyc %0d got {%0d,%0d} exp {%0d,%0d}",
                                  i, fl.freeReg_o[0], fl.freeReg_o[1], spec_q[0], spec_q[1]);
            end
         end
      end
      while (spec_q.size() > 0) begin
         cycle(1, 0, 2'b00, 0, 0, 0);
         if (spec_q.size() >= 1) begin
            n_tests++;
            if (fl.freeReg_o[0] !== 6'(spec_q[0])) begin
               n_fail++; $display("FAIL wrap_drain got %0d exp %0d", fl.freeReg_o[0], spec_q[0]);
            end
         end
      end
   endtask

   task automatic test_random();
      int inflight;
      bit en, sz, mis;
      bit [1:0] ret;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 3) != 0);
         sz  = 1'($urandom_range(0, 1));
         mis = ($urandom_range(0, 24) == 0);
         ret = 2'($urandom_range(0, 3));
         inflight = FLS - spec_q.size();
         if (inflight == 0) ret = 2'b00;
         else if (inflight == 1 && ret == 2'b11) ret = 2'b01;
         cycle(en, sz, ret, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), mis);
         n_tests++;
         if (fl.free_count_o !== 6'(spec_q.size()) ||
             fl.fl_empty_o !== (spec_q.size() == 0) ||
             fl.fl_one_left_o !== (spec_q.size() == 1)) begin
            n_fail++; $display("FAIL rnd_count cyc %0d got cnt=%0d e=%b o=%b exp cnt=%0d",
                               i, fl.free_count_o, fl.fl_empty_o, fl.fl_one_left_o, spec_q.size());
         end
         if (spec_q.size() >= 1) begin
            n_tests++;
            if (fl.freeReg_o[0] !== 6'(spec_q[0])) begin
               n_fail++; $display("FAIL rnd_tag0 cyc %0d got %0d exp %0d", i, fl.freeReg_o[0], spec_q[0]);
            end
         end
         if (spec_q.size() >= 2) begin
            n_tests++;
            if (fl.freeReg_o[1] !== 6'(spec_q[1])) begin
               n_fail++; $display("FAIL rnd_tag1 cyc %0d got %0d exp %0d", i, fl.freeReg_o[1], spec_q[1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_pop_sizes();
      test_drain_empty();
      test_mispredict();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
